omok_referee: RTL and testbench

Game-rule stage between cursor/button logic and the LCD renderer of the OMOK design. It accepts stone-placement requests at a board position and keeps separate black and white occupancy planes. After each placement it scans the four line directions through the new stone for five-in-a-row and alternates turns. It drives the occupancy planes, turn and winner to the display stage.

---
 rtl/omok_referee.sv | 256 +++++++++++++++++++++++++
 tb/tb_omok_referee.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/omok_referee.sv
// rtl/omok_referee.sv - Omok game-rule referee: placement, five-in-a-row scan, turn/winner tracking
//
// Purpose:
//   Accepts stone placements, keeps black/white occupancy planes and, after
//   every accepted stone, walks the four line directions through it one cell
//   per cycle to detect five (or more) in a row. Then it resolves win, draw or
//   turn change.
//
// Optional feature:
//   OMOK_UNDO_EN - one-entry undo history. When undefined, undo_req is ignored
//   and no history registers exist.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   put_req, put_pos  single-cycle placement request and target cell (row*N+col)
//   undo_req          single-cycle undo request
//   busy              scan/result in progress; requests ignored
//   reject            one-cycle pulse, the cycle after a refused request
//   black_board       bit pos set = black stone
//   white_board       bit pos set = white stone
//   turn              0 = black to move, 1 = white to move
//   game_over         win or draw reached
//   winner            00 none, 01 black, 10 white, 11 draw
//   move_count        stones on board

module omok_referee #(
  parameter int N       = 10,
  parameter int POS_W   = 7,
  parameter int CNT_W   = 7,
  parameter int WIN_LEN = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               put_req,
  input  logic [POS_W-1:0]   put_pos,
  input  logic               undo_req,
  output logic               busy,
  output logic               reject,
  output logic [N*N-1:0]     black_board,
  output logic [N*N-1:0]     white_board,
  output logic               turn,
  output logic               game_over,
  output logic [1:0]         winner,
  output logic [CNT_W-1:0]   move_count
);

  localparam int CELLS  = N * N;
  localparam int STEP_W = (WIN_LEN > 2) ? $clog2(WIN_LEN - 1) : 1;
  localparam int LEN_W  = $clog2(2 * WIN_LEN) + 1;
  // Wide enough for signed row/col walking off either edge and for row*N+col.
  localparam int RC_W   = POS_W + 2;

  localparam logic [STEP_W-1:0]      LAST_STEP = STEP_W'(WIN_LEN - 2);
  localparam logic signed [RC_W-1:0] ZERO_S    = '0;
  localparam logic signed [RC_W-1:0] N_S       = RC_W'(N);

  // PLACE is a spare encoding: placement happens on the request edge itself,
  // so IDLE goes straight to SCAN. PLACE is only a safe fall-through.
  typedef enum logic [1:0] {
    IDLE,
    PLACE,
    SCAN,
    RESULT
  } state_t;

  state_t state_q, state_d;

  // Scan bookkeeping
  logic [1:0]             dir;        // 0 H, 1 V, 2 D, 3 A
  logic                   neg;        // walking the negative sense
  logic [STEP_W-1:0]      step;       // 0 .. WIN_LEN-2
  logic                   blocked;
  logic [LEN_W-1:0]       line_len;
  logic                   win_flag;
  logic signed [RC_W-1:0] org_r, org_c;

  // Request decode
  logic             in_range, occupied, put_take, put_ok, put_bad;
  logic             undo_take, undo_ok, undo_bad;
  logic [CELLS-1:0] occ;

`ifdef OMOK_UNDO_EN
  logic [POS_W-1:0] hist_pos;
  logic             hist_valid;
`else
  logic             undo_req_unused;
  assign undo_req_unused = undo_req;
`endif

  assign busy = (state_q != IDLE);
  assign occ  = black_board | white_board;

  always_comb begin
    in_range  = ({1'b0, put_pos} < (POS_W + 1)'(CELLS));
    occupied  = in_range && occ[put_pos];
`ifdef OMOK_UNDO_EN
    undo_take = (state_q == IDLE) && undo_req;
    undo_ok   = undo_take && hist_valid;
    undo_bad  = undo_take && !hist_valid;
`else
    undo_take = 1'b0;
    undo_ok   = 1'b0;
    undo_bad  = 1'b0;
`endif
    // Undo wins over a simultaneous put; the put is dropped without reject.
    put_take  = (state_q == IDLE) && put_req && !undo_take;
    put_ok    = put_take && in_range && !occupied && !game_over;
    put_bad   = put_take && !put_ok;
  end

  // Current walk cell: origin + (step+1) * direction, in row/col space so a
  // walk never wraps from one row end into the next row.
  logic signed [RC_W-1:0] dr, dc, k, cur_r, cur_c, lin;
  logic [POS_W-1:0]       idx;
  logic [CELLS-1:0]       mover;
  logic                   on_board, hit, dir_end, scan_last;
  logic [LEN_W-1:0]       len_upd;

  always_comb begin
    dr = '0;
    dc = '0;
    case (dir)
      2'd0:    begin dr = ZERO_S;       dc = RC_W'(1);  end
      2'd1:    begin dr = RC_W'(1);     dc = ZERO_S;    end
      2'd2:    begin dr = RC_W'(1);     dc = RC_W'(1);  end
      default: begin dr = RC_W'(1);     dc = -RC_W'(1); end
    endcase
    if (neg) begin
      dr = -dr;
      dc = -dc;
    end
    k        = $signed(RC_W'(step) + RC_W'(1));
    cur_r    = org_r + dr * k;
    cur_c    = org_c + dc * k;
    on_board = (cur_r >= ZERO_S) && (cur_r < N_S) &&
               (cur_c >= ZERO_S) && (cur_c < N_S);
    lin      = cur_r * N_S + cur_c;
    idx      = POS_W'(lin);
    mover    = turn ? white_board : black_board;
    hit      = !blocked && on_board && mover[idx];
    len_upd  = line_len + LEN_W'(hit);
    dir_end  = (step == LAST_STEP) && neg;
    scan_last = dir_end && (dir == 2'd3);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (put_ok) state_d = SCAN;
      PLACE:   state_d = SCAN;
      SCAN:    if (scan_last) state_d = RESULT;
      RESULT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Board, turn, result and scan datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      black_board <= '0;
      white_board <= '0;
      turn        <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 2'b00;
      move_count  <= '0;
      reject      <= 1'b0;
      dir         <= 2'd0;
      neg         <= 1'b0;
      step        <= '0;
      blocked     <= 1'b0;
      line_len    <= LEN_W'(1);
      win_flag    <= 1'b0;
      org_r       <= '0;
      org_c       <= '0;
`ifdef OMOK_UNDO_EN
      hist_pos    <= '0;
      hist_valid  <= 1'b0;
`endif
    end else begin
      reject <= put_bad | undo_bad;

      if (put_ok) begin
        if (turn) white_board[put_pos] <= 1'b1;
        else      black_board[put_pos] <= 1'b1;
        move_count <= move_count + CNT_W'(1);
        org_r      <= RC_W'(put_pos / N);
        org_c      <= RC_W'(put_pos % N);
        dir        <= 2'd0;
        neg        <= 1'b0;
        step       <= '0;
        blocked    <= 1'b0;
        line_len   <= LEN_W'(1);
        win_flag   <= 1'b0;
`ifdef OMOK_UNDO_EN
        hist_pos   <= put_pos;
        hist_valid <= 1'b1;
`endif
      end

`ifdef OMOK_UNDO_EN
      if (undo_ok) begin
        black_board[hist_pos] <= 1'b0;
        white_board[hist_pos] <= 1'b0;
        move_count            <= move_count - CNT_W'(1);
        // The removed stone's owner moves again.
        turn                  <= white_board[hist_pos];
        game_over             <= 1'b0;
        winner                <= 2'b00;
        hist_valid            <= 1'b0;
      end
`endif

      if (state_q == SCAN) begin
        if (step == LAST_STEP) begin
          step    <= '0;
          blocked <= 1'b0;
          if (neg) begin
            // Direction finished: new stone + both runs
            if (len_upd >= LEN_W'(WIN_LEN)) win_flag <= 1'b1;
            neg      <= 1'b0;
            dir      <= dir + 2'd1;
            line_len <= LEN_W'(1);
          end else begin
            neg      <= 1'b1;
            line_len <= len_upd;
          end
        end else begin
          step     <= step + STEP_W'(1);
          line_len <= len_upd;
          // Once blocked, the rest of this walk only burns cycles.
          blocked  <= blocked | !hit;
        end
      end

      if (state_q == RESULT) begin
        if (win_flag) begin
          game_over <= 1'b1;
          winner    <= turn ? 2'b10 : 2'b01;
        end else if (move_count == CNT_W'(CELLS)) begin
          game_over <= 1'b1;
          winner    <= 2'b11;
        end else begin
          turn <= ~turn;
        end
      end
    end
  end

endmodule

// File: tb/tb_omok_referee.sv
// tb/tb_omok_referee.sv - Randomized self-checking bench for omok_referee against a board-array model

module tb_omok_referee;

  localparam int N        = 10;
  localparam int POS_W    = 7;
  localparam int CNT_W    = 7;
  localparam int WIN_LEN  = 5;
  localparam int CELLS    = N * N;
  localparam int SCAN_CYC = 8 * (WIN_LEN - 1) + 1;
`ifdef OMOK_UNDO_EN
  localparam bit UNDO = 1'b1;
`else
  localparam bit UNDO = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             put_req = 1'b0;
  logic [POS_W-1:0] put_pos = '0;
  logic             undo_req = 1'b0;
  logic             busy, reject, turn, game_over;
  logic [CELLS-1:0] black_board, white_board;
  logic [1:0]       winner;
  logic [CNT_W-1:0] move_count;

  omok_referee #(.N(N), .POS_W(POS_W), .CNT_W(CNT_W), .WIN_LEN(WIN_LEN)) dut (
    .clk(clk), .rst(rst), .put_req(put_req), .put_pos(put_pos), .undo_req(undo_req),
    .busy(busy), .reject(reject), .black_board(black_board), .white_board(white_board),
    .turn(turn), .game_over(game_over), .winner(winner), .move_count(move_count)
  );

  always #5 clk = ~clk;

  // Reference model: 0 empty, 1 black, 2 white
  int       bd[CELLS];
  bit       m_turn, m_over, m_hv;
  logic [1:0] m_win;
  int       m_cnt, m_hp;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CELLS-1:0] plane(input int c);
    logic [CELLS-1:0] v;
    v = '0;
    for (int i = 0; i < CELLS; i++) v[i] = (bd[i] == c);
    return v;
  endfunction

  function automatic bit line_win(input int p, input int c);
    int dr[4];
    int dc[4];
    int r0, c0, len, r, cc;
    bit stop;
    dr = '{0, 1, 1, 1};
    dc = '{1, 0, 1, -1};
    r0 = p / N;
    c0 = p % N;
    for (int d = 0; d < 4; d++) begin
      len = 1;
      for (int s = -1; s <= 1; s += 2) begin
        stop = 0;
        for (int k = 1; k < WIN_LEN; k++) begin
          r  = r0 + s * k * dr[d];
          cc = c0 + s * k * dc[d];
          if (!stop) begin
            if (r < 0 || r >= N || cc < 0 || cc >= N) stop = 1;
            else if (bd[r * N + cc] != c) stop = 1;
            else len++;
          end
        end
      end
      if (len >= WIN_LEN) return 1;
    end
    return 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < CELLS; i++) bd[i] = 0;
    m_turn = 0; m_over = 0; m_win = 2'b00; m_cnt = 0; m_hv = 0; m_hp = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_black"}, black_board, plane(1));
    check({tag, "_white"}, white_board, plane(2));
    check({tag, "_turn"}, turn, m_turn);
    check({tag, "_over"}, game_over, m_over);
    check({tag, "_winner"}, winner, m_win);
    check({tag, "_count"}, move_count, m_cnt);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; put_req = 0; undo_req = 0; put_pos = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    model_clear();
    check_all("reset");
  endtask

  // One request, model update, then result comparisons once the DUT settles.
  task automatic req(input bit p, input int pos, input bit u);
    bit exp_rej, acc;
    int n, col;
    exp_rej = 0;
    acc = 0;
    @(negedge clk);
    put_req = p; put_pos = POS_W'(pos); undo_req = u;
    if (UNDO && u) begin
      if (m_hv) begin
        col = bd[m_hp];
        bd[m_hp] = 0;
        m_cnt--;
        m_turn = (col == 2);
        m_over = 0; m_win = 2'b00; m_hv = 0;
      end else exp_rej = 1;
    end else if (p) begin
      if (pos >= CELLS || m_over) exp_rej = 1;
      else if (bd[pos] != 0) exp_rej = 1;
      else begin
        acc = 1;
        bd[pos] = m_turn ? 2 : 1;
        m_cnt++;
        m_hv = 1;
        m_hp = pos;
      end
    end
    @(negedge clk);
    put_req = 0; undo_req = 0;
    check("reject", reject, exp_rej);
    check("busy_start", busy, acc);
    if (acc) begin
      check("plane_early", m_turn ? white_board[pos] : black_board[pos], 1);
      check("count_early", move_count, m_cnt);
      n = 0;
      while (busy && n < 200) begin
        n++;
        @(negedge clk);
      end
      check("busy_len", n, SCAN_CYC);
      if (line_win(pos, bd[pos])) begin
        m_over = 1;
        m_win = m_turn ? 2'b10 : 2'b01;
      end else if (m_cnt == CELLS) begin
        m_over = 1;
        m_win = 2'b11;
      end else m_turn = !m_turn;
    end
    check_all("after");
    if (exp_rej) begin
      @(negedge clk);
      check("reject_fall", reject, 0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    do_reset();

    // First move and refusals
    req(1, 44, 0);
    check("first_turn", turn, 1);
    check("first_b44", black_board[44], 1);
    req(1, 44, 0);
    req(1, 100, 0);
    check("refused_turn", turn, 1);

    // Black wins on row 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req(1, i, 0);
      req(1, 90 + i, 0);
    end
    req(1, 4, 0);
    check("win_over", game_over, 1);
    check("win_black", winner, 2'b01);
    req(1, 50, 0);
    req(0, 0, 1);
`ifdef OMOK_UNDO_EN
    check("undo_b4", black_board[4], 0);
    check("undo_winner", winner, 2'b00);
    check("undo_turn", turn, 0);
    check("undo_count", move_count, 8);
    req(0, 0, 1);
    check("undo2_count", move_count, 8);
`else
    check("noundo_winner", winner, 2'b01);
`endif

    // Five across a row end is not a line
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req(1, 7 + i, 0);
      req(1, 90 + i, 0);
    end
    req(1, 11, 0);
    check("wrap_over", game_over, 0);
    check("wrap_winner", winner, 2'b00);

    // Asynchronous reset in the middle of a scan
    do_reset();
    req(1, 20, 0);
    @(negedge clk);
    put_req = 1; put_pos = POS_W'(33);
    @(negedge clk);
    put_req = 0;
    repeat (5) @(negedge clk);
    #2 rst = 1;
    #1;
    check("midscan_busy", busy, 0);
    check("midscan_black", black_board, 0);
    check("midscan_count", move_count, 0);
    do_reset();

    // Random games, positions biased toward a sub-board for quicker lines
    for (int g = 0; g < 4; g++) begin
      do_reset();
      for (int t = 0; t < 120 && !m_over; t++) begin
        bit u, p;
        int pos;
        u = ($urandom_range(0, 9) == 0);
        p = !u || ($urandom_range(0, 1) == 1);
        pos = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, CELLS + 20))
                                          : int'($urandom_range(2, 6)) * N + int'($urandom_range(2, 7));
        req(p, pos, u);
      end
      req(1, int'($urandom_range(0, CELLS - 1)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
